// File: rtl/mergesort_pkg.sv
// Shared types, sizes, address map and initial-value table for the merge-sort kernel.
package mergesort_pkg;
  localparam int N      = 16;
  localparam int ELEM_W = 16;

  localparam int MEM_var_28859_28863 = 64;  // data array byte base
  localparam int MEM_var_28861_28867 = 32;  // scratch array byte base
  localparam int MEM_var_29014_28863 = 32;  // initial-value ROM base (internal bank only)

  typedef logic signed [ELEM_W-1:0] elem_t;
  typedef elem_t arr_t [N];

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, COPY, DONE} state_e;

  function automatic elem_t rom_elem(input logic [3:0] idx);
    elem_t v;
    case (idx)
      4'd0:  v = 16'sd15;
      4'd1:  v = -16'sd3;
      4'd2:  v = 16'sd7;
      4'd3:  v = 16'sd0;
      4'd4:  v = 16'sd32767;
      4'd5:  v = 16'sh8000;
      4'd6:  v = 16'sd2;
      4'd7:  v = 16'sd2;
      4'd8:  v = 16'sd100;
      4'd9:  v = -16'sd1;
      4'd10: v = 16'sd9;
      4'd11: v = 16'sd4;
      4'd12: v = 16'sd8;
      4'd13: v = 16'sd1;
      4'd14: v = -16'sd7;
      default: v = 16'sd3;
    endcase
    return v;
  endfunction
endpackage

// File: rtl/mergesort_if.sv
// Bundle of start/done and the two-channel byte slave port of the merge-sort kernel.
// Slave access: oe or we sampled at a rising edge is acknowledged by Sout_DataRdy[i] for exactly
// the following cycle, carrying the read byte (or 0 for writes); there is no back-pressure.
interface mergesort_if;
  import mergesort_pkg::*;
  logic        start_port;
  logic [1:0]  S_oe_ram;
  logic [1:0]  S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;
  state_e      dbg_state;

  modport master (output start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
                  input done_port, Sout_Rdata_ram, Sout_DataRdy, dbg_state);
  modport slave  (input start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
                  output done_port, Sout_Rdata_ram, Sout_DataRdy, dbg_state);
endinterface

// File: rtl/mergesort_slave_if.sv
// One slave channel: decodes the byte address onto data/scratch, selects the read byte and
// registers the acknowledge; write strobes go back to the top, which owns the arrays.
module mergesort_slave_if
  import mergesort_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       idle,
  input  logic       oe,
  input  logic       we,
  input  logic [6:0] addr,
  input  arr_t       data_arr,
  input  arr_t       scr_arr,
  output logic       wr_en,
  output logic       wr_to_data,
  output logic [3:0] wr_elem,
  output logic       wr_hi,
  output logic [7:0] rdata,
  output logic       rdy
);
  localparam logic [6:0] DATA_BASE = 7'(MEM_var_28859_28863);
  localparam logic [6:0] SCR_BASE  = 7'(MEM_var_28861_28867);

  logic       in_data, in_scr;
  logic [6:0] data_off, scr_off;
  elem_t      sel_word;
  logic [7:0] rdata_d, rdata_q;
  logic       rdy_d, rdy_q;

  // Offsets wrap for addresses below the base, so a single compare covers both bounds.
  assign data_off = addr - DATA_BASE;
  assign scr_off  = addr - SCR_BASE;
  assign in_data  = data_off < 7'd32;
  assign in_scr   = scr_off < 7'd32;

  assign wr_elem    = addr[4:1];
  assign wr_hi      = addr[0];
  assign wr_to_data = in_data;
  assign wr_en      = we && idle && (in_data || in_scr);

  always_comb begin
    sel_word = '0;
    if (in_scr)       sel_word = scr_arr[addr[4:1]];
    else if (in_data) sel_word = data_arr[addr[4:1]];
    rdata_d = '0;
    if (oe && !we && idle) rdata_d = addr[0] ? sel_word[15:8] : sel_word[7:0];
    rdy_d = oe || we;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdata = rdata_q;
  assign rdy   = rdy_q;
endmodule

// File: rtl/mergesort_main.sv
// Merge-sort kernel: loads the ROM table into the data array, sorts it bottom-up through the
// scratch array one element per cycle, then pulses done. Arrays are not reset.
module mergesort_main
  import mergesort_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  mergesort_if.slave bus
);
  state_e     state_q, state_d;
  logic [5:0] k_q, k_d, i_q, i_d, j_q, j_d, lo_q, lo_d;
  logic [4:0] w_q, w_d;
  arr_t       data_q, data_d, scr_q, scr_d;

  logic [5:0] w2, left_end, run_end;
  logic       left_ok, right_ok, take_left;
  logic       wr_en [2];
  logic       wr_to_data [2];
  logic       wr_hi [2];
  logic [3:0] wr_elem [2];
  logic [7:0] wbyte [2];
  logic [7:0] rdata [2];
  logic       rdy [2];
  logic       size_unused;

  // Access size is always treated as one byte.
  assign size_unused = ^bus.S_data_ram_size;
  assign wbyte[0] = bus.S_Wdata_ram[7:0];
  assign wbyte[1] = bus.S_Wdata_ram[15:8];

  mergesort_slave_if u_ch0 (
    .clock(clock), .reset(reset), .idle(state_q == IDLE),
    .oe(bus.S_oe_ram[0]), .we(bus.S_we_ram[0]), .addr(bus.S_addr_ram[6:0]),
    .data_arr(data_q), .scr_arr(scr_q),
    .wr_en(wr_en[0]), .wr_to_data(wr_to_data[0]), .wr_elem(wr_elem[0]), .wr_hi(wr_hi[0]),
    .rdata(rdata[0]), .rdy(rdy[0])
  );

  mergesort_slave_if u_ch1 (
    .clock(clock), .reset(reset), .idle(state_q == IDLE),
    .oe(bus.S_oe_ram[1]), .we(bus.S_we_ram[1]), .addr(bus.S_addr_ram[13:7]),
    .data_arr(data_q), .scr_arr(scr_q),
    .wr_en(wr_en[1]), .wr_to_data(wr_to_data[1]), .wr_elem(wr_elem[1]), .wr_hi(wr_hi[1]),
    .rdata(rdata[1]), .rdy(rdy[1])
  );

  assign w2        = {w_q, 1'b0};
  assign left_end  = lo_q + {1'b0, w_q};
  assign run_end   = lo_q + w2;
  assign left_ok   = i_q < left_end;
  assign right_ok  = j_q < run_end;
  // Ties take the left head so equal keys keep their order.
  assign take_left = left_ok && (!right_ok || (data_q[i_q[3:0]] <= data_q[j_q[3:0]]));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    lo_d    = lo_q;
    w_d     = w_q;
    data_d  = data_q;
    scr_d   = scr_q;
    case (state_q)
      IDLE: begin
        if (bus.start_port) begin
          state_d = LOAD;
          k_d     = '0;
        end
      end
      LOAD: begin
        data_d[k_q[3:0]] = rom_elem(k_q[3:0]);
        k_d = k_q + 6'd1;
        if (k_q == 6'd15) begin
          state_d = MERGE;
          k_d     = '0;
          w_d     = 5'd1;
          lo_d    = '0;
          i_d     = '0;
          j_d     = 6'd1;
        end
      end
      MERGE: begin
        scr_d[k_q[3:0]] = take_left ? data_q[i_q[3:0]] : data_q[j_q[3:0]];
        if (take_left) i_d = i_q + 6'd1;
        else           j_d = j_q + 6'd1;
        k_d = k_q + 6'd1;
        if (k_q == run_end - 6'd1) begin
          lo_d = run_end;
          i_d  = run_end;
          j_d  = run_end + {1'b0, w_q};
        end
        if (k_q == 6'd15) begin
          state_d = COPY;
          k_d     = '0;
        end
      end
      COPY: begin
        data_d[k_q[3:0]] = scr_q[k_q[3:0]];
        k_d = k_q + 6'd1;
        if (k_q == 6'd15) begin
          k_d     = '0;
          w_d     = w_q << 1;
          lo_d    = '0;
          i_d     = '0;
          j_d     = w2;
          state_d = (w_q == 5'd8) ? DONE : MERGE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Slave writes only assert while idle; channel 1 is applied last so it wins a collision.
    for (int c = 0; c < 2; c++) begin
      if (wr_en[c]) begin
        if (wr_to_data[c]) begin
          if (wr_hi[c]) data_d[wr_elem[c]][15:8] = wbyte[c];
          else          data_d[wr_elem[c]][7:0]  = wbyte[c];
        end else begin
          if (wr_hi[c]) scr_d[wr_elem[c]][15:8] = wbyte[c];
          else          scr_d[wr_elem[c]][7:0]  = wbyte[c];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      lo_q    <= '0;
      w_q     <= 5'd1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      lo_q    <= lo_d;
      w_q     <= w_d;
    end
  end

  always_ff @(posedge clock) begin
    data_q <= data_d;
    scr_q  <= scr_d;
  end

  assign bus.done_port      = (state_q == DONE);
  assign bus.Sout_Rdata_ram = {rdata[1], rdata[0]};
  assign bus.Sout_DataRdy   = {rdy[1], rdy[0]};
  assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_mergesort_main.sv
// Bench for mergesort_main: latency/done checks, sorted readback and slave-port corner cases.
module tb_mergesort_main;
  import mergesort_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [7:0] exp_q[$];
  int   rom_vals[16] = '{15, -3, 7, 0, 32767, -32768, 2, 2, 100, -1, 9, 4, 8, 1, -7, 3};
  int   sorted[16];

  mergesort_if bus ();

  mergesort_main dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: one cycle on both slave channels; expected read bytes go to the scoreboard
  task automatic slave_cycle(input logic [1:0] oe, input logic [1:0] we,
                             input logic [6:0] a0, input logic [6:0] a1,
                             input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] e;
    bus.S_oe_ram    = oe;
    bus.S_we_ram    = we;
    bus.S_addr_ram  = {a1, a0};
    bus.S_Wdata_ram = {w1, w0};
    if (oe[0] || we[0]) exp_q.push_back(e0);
    if (oe[1] || we[1]) exp_q.push_back(e1);
    tick();
    bus.S_oe_ram = '0;
    bus.S_we_ram = '0;
    check("data_rdy", {30'd0, bus.Sout_DataRdy}, {30'd0, oe | we});
    for (int ch = 0; ch < 2; ch++) begin
      if (bus.Sout_DataRdy[ch]) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check(ch == 0 ? "rdata_ch0" : "rdata_ch1", {24'd0, bus.Sout_Rdata_ram[8*ch +: 8]}, {24'd0, e});
        end
      end
    end
  endtask

  // Start a sort and watch done for a bounded window. mode 1 adds a second start and a
  // busy-time write in the middle of the sort.
  task automatic run_sort(input int mode);
    int first;
    int done_cnt;
    first    = -1;
    done_cnt = 0;
    bus.start_port = 1'b1;
    tick();
    bus.start_port = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (mode == 1 && c == 49) bus.start_port = 1'b1;
      if (mode == 1 && c == 60) begin
        slave_cycle(2'b01, 2'b01, 7'd64, 7'd0, 8'hAA, 8'h00, 8'h00, 8'h00);
        check("busy_state", 32'(bus.dbg_state == IDLE), 32'd0);
      end else begin
        tick();
      end
      bus.start_port = 1'b0;
      if (bus.done_port === 1'b1) begin
        done_cnt++;
        if (first < 0) first = c;
      end
    end
    check("done_latency", first, 144);
    check("done_count", done_cnt, 1);
  endtask

  task automatic read_data_array();
    int v;
    for (int k = 0; k < 16; k++) begin
      v = sorted[k];
      slave_cycle(2'b11, 2'b00, 7'(64 + 2 * k), 7'(65 + 2 * k), 8'h00, 8'h00,
                  8'(v & 255), 8'((v >>> 8) & 255));
    end
  endtask

  initial begin
    int t;
    int dcnt;
    n_tests = 0;
    n_fail  = 0;
    // reference: insertion sort of the table
    for (int i = 0; i < 16; i++) sorted[i] = rom_vals[i];
    for (int i = 1; i < 16; i++) begin
      t = sorted[i];
      for (int j = i - 1; j >= 0; j--) begin
        if (sorted[j] > t) begin
          sorted[j + 1] = sorted[j];
          sorted[j] = t;
        end
      end
    end

    bus.start_port      = 1'b0;
    bus.S_oe_ram        = '0;
    bus.S_we_ram        = '0;
    bus.S_addr_ram      = '0;
    bus.S_Wdata_ram     = '0;
    bus.S_data_ram_size = 8'h88;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_done", {31'd0, bus.done_port}, 32'd0);
    check("rst_rdy", {30'd0, bus.Sout_DataRdy}, 32'd0);
    check("rst_rdata", {16'd0, bus.Sout_Rdata_ram}, 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    tick();

    // plain sort
    run_sort(0);
    read_data_array();

    // element 0 spot check via two channels and the slave corner cases
    slave_cycle(2'b11, 2'b00, 7'd64, 7'd65, 8'h00, 8'h00, 8'h00, 8'h80);
    slave_cycle(2'b00, 2'b10, 7'd0, 7'd32, 8'h00, 8'h55, 8'h00, 8'h00);
    slave_cycle(2'b10, 2'b00, 7'd0, 7'd32, 8'h00, 8'h00, 8'h00, 8'h55);
    slave_cycle(2'b01, 2'b00, 7'd120, 7'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    slave_cycle(2'b00, 2'b11, 7'd33, 7'd33, 8'h11, 8'h22, 8'h00, 8'h00);
    slave_cycle(2'b01, 2'b00, 7'd33, 7'd0, 8'h00, 8'h00, 8'h22, 8'h00);
    slave_cycle(2'b01, 2'b01, 7'd34, 7'd0, 8'h77, 8'h00, 8'h00, 8'h00);
    slave_cycle(2'b01, 2'b00, 7'd34, 7'd0, 8'h00, 8'h00, 8'h77, 8'h00);
    slave_cycle(2'b00, 2'b01, 7'd0, 7'd0, 8'h00, 8'h99, 8'h00, 8'h00);
    slave_cycle(2'b11, 2'b00, 7'd0, 7'd127, 8'h00, 8'h00, 8'h00, 8'h00);
    // data array writable when idle
    slave_cycle(2'b00, 2'b01, 7'd66, 7'd0, 8'h3C, 8'h00, 8'h00, 8'h00);
    slave_cycle(2'b01, 2'b00, 7'd66, 7'd0, 8'h00, 8'h00, 8'h3C, 8'h00);

    // second start and busy write are ignored
    run_sort(1);
    read_data_array();

    // reset mid-sort aborts without done
    bus.start_port = 1'b1;
    tick();
    bus.start_port = 1'b0;
    for (int c = 1; c < 60; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_state", 32'(bus.dbg_state), 32'(IDLE));
    dcnt = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus.done_port !== 1'b0) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run_sort(0);
    read_data_array();

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
